// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared CRAM configuration types, CRC constant and chain-length helper
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // LUT bits + FF-bypass per output + switch box (6 per track) + input connection muxes
    function automatic int cfg_bits(input int bus_width, input int le_inputs,
                                    input int le_outputs, input int lut_size);
        return lut_size + le_outputs + 6 * bus_width + le_inputs * (4 * bus_width + 1);
    endfunction

endpackage

// File: rtl/cram_loader_if.sv
// rtl/cram_loader_if.sv - bitstream word handshake between producer and cram_loader
interface cram_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/cfg_crc8.sv
// rtl/cfg_crc8.sv - serial CRC-8 (poly 0x07, init 0x00), one bit per enabled clock, MSB-first
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);
    logic fb;

    assign fb = crc[7] ^ bit_in;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end
endmodule

// File: rtl/cram_loader.sv
// rtl/cram_loader.sv - serialises bitstream words MSB-first onto the CRAM chain; LOADER_CRC_EN adds a CRC-8 trailer check
module cram_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CHAIN_LEN  = cfg_bits(4, 4, 1, 16)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    cram_loader_if.slave        wbus,
    output logic                config_data_in,
    output logic                config_en,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int NWORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int NBITS  = NWORDS * WORD_WIDTH;
`ifdef LOADER_CRC_EN
    localparam int NACCEPT = NWORDS + 1;
`else
    localparam int NACCEPT = NWORDS;
`endif
    localparam int WA_W = $clog2(NACCEPT + 1);
    localparam int BC_W = $clog2(NBITS + 1);
    localparam int SC_W = $clog2(WORD_WIDTH + 1);

    loader_state_t         state, state_nxt;
    logic [WORD_WIDTH-1:0] shreg, hold;
    logic [SC_W-1:0]       sh_cnt, sh_left;
    logic                  hold_full;
    logic [WA_W-1:0]       words_acc;
    logic [BC_W-1:0]       bits_sent;
    logic                  start_load, accept, accept_data, shifting, bits_done;
`ifdef LOADER_CRC_EN
    logic [7:0]            crc_rx, crc_calc;
    logic                  crc_full;
`endif

    assign start_load      = start && (state == IDLE || state == DONE);
    assign wbus.word_ready = (state == LOAD) && !hold_full && (words_acc < WA_W'(NACCEPT));
    assign accept          = wbus.word_valid && wbus.word_ready;
    assign accept_data     = accept && (words_acc < WA_W'(NWORDS));
    assign shifting        = (state == LOAD) && (sh_cnt != '0);
    assign bits_done       = (bits_sent == BC_W'(NBITS));

    always_comb begin
        sh_left = sh_cnt;
        if (shifting) sh_left = sh_cnt - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
`ifdef LOADER_CRC_EN
            LOAD:  if (bits_done && crc_full) state_nxt = CHECK;
`else
            LOAD:  if (bits_done) state_nxt = DONE;
`endif
            CHECK: state_nxt = DONE;
            DONE:  if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            config_en      <= 1'b0;
            config_data_in <= 1'b0;
            shreg          <= '0;
            hold           <= '0;
            sh_cnt         <= '0;
            hold_full      <= 1'b0;
            words_acc      <= '0;
            bits_sent      <= '0;
        end else begin
            state          <= state_nxt;
            busy           <= (state_nxt == LOAD) || (state_nxt == CHECK);
            done           <= (state_nxt == DONE);
            config_en      <= shifting;
            config_data_in <= shifting ? shreg[WORD_WIDTH-1] : 1'b0;
            if (start_load) begin
                sh_cnt    <= '0;
                hold_full <= 1'b0;
                words_acc <= '0;
                bits_sent <= '0;
            end else begin
                if (accept)   words_acc <= words_acc + 1'b1;
                if (shifting) bits_sent <= bits_sent + 1'b1;
                // Refill the shifter in the same cycle its last bit leaves so a steady source stays gapless
                if (sh_left == '0 && hold_full) begin
                    shreg     <= hold;
                    sh_cnt    <= SC_W'(WORD_WIDTH);
                    hold_full <= 1'b0;
                end else if (sh_left == '0 && accept_data) begin
                    shreg  <= wbus.word_in;
                    sh_cnt <= SC_W'(WORD_WIDTH);
                end else begin
                    if (shifting) begin
                        shreg  <= shreg << 1;
                        sh_cnt <= sh_left;
                    end
                    if (accept_data) begin
                        hold      <= wbus.word_in;
                        hold_full <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef LOADER_CRC_EN
    cfg_crc8 u_crc (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (start_load),
        .en     (shifting),
        .bit_in (shreg[WORD_WIDTH-1]),
        .crc    (crc_calc)
    );

    // The trailer word only carries the expected CRC; it never enters the shifter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_rx   <= 8'h00;
            crc_full <= 1'b0;
            err      <= 1'b0;
        end else if (start_load) begin
            crc_full <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept && !accept_data) begin
                crc_rx   <= wbus.word_in[7:0];
                crc_full <= 1'b1;
            end
            if (state == CHECK) err <= (crc_calc != crc_rx);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cram_loader.sv
// tb/tb_cram_loader.sv - directed self-checking bench for cram_loader with a behavioural CRAM chain
module tb_cram_loader;
    localparam int W  = 8;
    localparam int CL = 109;
    localparam int NW = 14;
    localparam int NB = 112;
`ifdef LOADER_CRC_EN
    localparam int NT = NW + 1;
    localparam int DONE_LAT = 2;
`else
    localparam int NT = NW;
    localparam int DONE_LAT = 1;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic cfg_d, cfg_en, busy, done, err;

    cram_loader_if #(.WORD_WIDTH(W)) wbus ();

    cram_loader #(.WORD_WIDTH(W), .CHAIN_LEN(CL)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .wbus           (wbus),
        .config_data_in (cfg_d),
        .config_en      (cfg_en),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0]    words [16];
    logic [NB-1:0] exp_stream;
    logic [CL-1:0] chain;
    int   cyc = 0;
    int   done_rise = -1;
    logic done_d = 1'b0;
    bit   bits_q [$];
    int   en_cyc_q [$];

    // Behavioural CRAM chain: samples the loader outputs on each rising edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_en === 1'b1) begin
            bits_q.push_back(cfg_d);
            en_cyc_q.push_back(cyc);
            chain <= {chain[CL-2:0], cfg_d};
        end
        if (done === 1'b1 && done_d !== 1'b1) done_rise <= cyc;
        done_d <= done;
    end

    function automatic logic [7:0] crc8_of(input logic [NB-1:0] s);
        logic [7:0] c = 8'h00;
        logic fb;
        for (int j = NB - 1; j >= 0; j--) begin
            fb = c[7] ^ s[j];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic build(input bit incr, input logic [7:0] seed);
        for (int i = 0; i < NW; i++) begin
            words[i] = incr ? 8'(seed + 8'(i * 29)) : seed;
            exp_stream[NB-1-8*i -: 8] = words[i];
        end
        words[NW] = crc8_of(exp_stream);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed(input int first, input int last_excl, input int gap_at, input int gap_len);
        int i = first;
        int g = 0;
        int guard = 0;
        while (i < last_excl && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (!nrst) break;
            if (i == gap_at && g < gap_len) begin
                wbus.word_valid = 1'b0;
                g++;
            end else begin
                wbus.word_valid = 1'b1;
                wbus.word_in    = words[i];
                if (wbus.word_ready === 1'b1) i++;
            end
        end
        if (nrst && i != last_excl) begin
            checks++; errors++;
            $display("FAIL feed_timeout: accepted up to %0d, required %0d", i, last_excl);
        end
        @(negedge clk);
        wbus.word_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
    endtask

    task automatic check_load(input string tag, input int base, input int ebase, input int exp_span);
        int n_en, span, bad;
        n_en = bits_q.size() - base;
        span = (en_cyc_q.size() > ebase) ? en_cyc_q[$] - en_cyc_q[ebase] + 1 : -1;
        bad = 0;
        for (int j = 0; j < NB; j++)
            if (base + j >= bits_q.size() || bits_q[base+j] !== exp_stream[NB-1-j]) bad++;
        checks++;
        if (n_en !== NB) begin errors++; $display("FAIL %s_en_count: got %0d required %0d", tag, n_en, NB); end
        checks++;
        if (span !== exp_span) begin errors++; $display("FAIL %s_en_span: got %0d required %0d", tag, span, exp_span); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL %s_bit_order: %0d wrong bits, required 0", tag, bad); end
        checks++;
        if (chain !== exp_stream[CL-1:0]) begin errors++; $display("FAIL %s_chain: got %h required %h", tag, chain, exp_stream[CL-1:0]); end
        checks++;
        if (en_cyc_q.size() == 0 || done_rise !== en_cyc_q[$] + DONE_LAT) begin
            errors++;
            $display("FAIL %s_done_latency: done rose at %0d, required %0d", tag, done_rise,
                     (en_cyc_q.size() == 0) ? -1 : en_cyc_q[$] + DONE_LAT);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL %s_busy_err: busy=%b err=%b required 0 0", tag, busy, err); end
    endtask

    task automatic test_reset();
        wbus.word_valid = 1'b0;
        wbus.word_in    = '0;
        repeat (3) @(negedge clk);
        checks++; if (wbus.word_ready !== 1'b0) begin errors++; $display("FAIL reset_word_ready: got %b required 0", wbus.word_ready); end
        checks++; if (cfg_en !== 1'b0) begin errors++; $display("FAIL reset_config_en: got %b required 0", cfg_en); end
        checks++; if (cfg_d !== 1'b0) begin errors++; $display("FAIL reset_config_data_in: got %b required 0", cfg_d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        nrst = 1'b1;
    endtask

    task automatic test_back_to_back();
        int base, ebase;
        build(1'b0, 8'hA5);
        base = bits_q.size(); ebase = en_cyc_q.size();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", busy); end
        feed(0, NT, -1, 0);
        wait_done();
        @(negedge clk);
        check_load("b2b", base, ebase, NB);
    endtask

    task automatic test_gap();
        int base, ebase;
        build(1'b0, 8'hA5);
        base = bits_q.size(); ebase = en_cyc_q.size();
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_start_clears_done: got %b required 0", done); end
        feed(0, NT, 6, 20);
        wait_done();
        @(negedge clk);
        check_load("gap", base, ebase, NB + 6);
    endtask

    task automatic test_ignored();
        int base, ebase, ready_seen;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        base = bits_q.size();
        ready_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wbus.word_valid = 1'b1;
            wbus.word_in    = 8'hFF;
            if (wbus.word_ready !== 1'b0) ready_seen++;
        end
        @(negedge clk); wbus.word_valid = 1'b0;
        checks++; if (ready_seen !== 0) begin errors++; $display("FAIL idle_word_ready: high %0d cycles, required 0", ready_seen); end
        checks++; if (bits_q.size() !== base || busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_shift: bits=%0d busy=%b required 0 0", bits_q.size() - base, busy);
        end
        build(1'b1, 8'h3C);
        base = bits_q.size(); ebase = en_cyc_q.size();
        pulse_start();
        feed(0, 7, -1, 0);
        pulse_start();
        feed(7, NT, -1, 0);
        wait_done();
        @(negedge clk);
        checks++; if (bits_q.size() - base !== NB) begin errors++; $display("FAIL midstart_en_count: got %0d required %0d", bits_q.size() - base, NB); end
        checks++; if (chain !== exp_stream[CL-1:0]) begin errors++; $display("FAIL midstart_chain: got %h required %h", chain, exp_stream[CL-1:0]); end
        base = bits_q.size();
        ready_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wbus.word_valid = 1'b1;
            if (wbus.word_ready !== 1'b0) ready_seen++;
        end
        @(negedge clk); wbus.word_valid = 1'b0;
        checks++; if (ready_seen !== 0 || bits_q.size() !== base) begin
            errors++; $display("FAIL done_valid_ignored: ready cycles=%0d extra bits=%0d required 0 0", ready_seen, bits_q.size() - base);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_level_held: got %b required 1", done); end
    endtask

    task automatic test_reset_mid();
        int base, ebase;
        build(1'b1, 8'h5A);
        base = bits_q.size();
        pulse_start();
        fork
            feed(0, NT, -1, 0);
            begin
                int n = 0;
                while (bits_q.size() - base < 50 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (bits_q.size() - base !== 50) begin errors++; $display("FAIL midreset_reach_bit50: got %0d required 50", bits_q.size() - base); end
                #2 nrst = 1'b0;
                #1;
                checks++; if (cfg_en !== 1'b0 || cfg_d !== 1'b0) begin errors++; $display("FAIL midreset_cfg: en=%b data=%b required 0 0", cfg_en, cfg_d); end
                checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                    errors++; $display("FAIL midreset_status: busy=%b done=%b err=%b required 0 0 0", busy, done, err);
                end
                checks++; if (wbus.word_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b required 0", wbus.word_ready); end
            end
        join
        @(negedge clk); nrst = 1'b1;
        base = bits_q.size(); ebase = en_cyc_q.size();
        pulse_start();
        feed(0, NT, -1, 0);
        wait_done();
        @(negedge clk);
        check_load("restart", base, ebase, NB);
    endtask

`ifdef LOADER_CRC_EN
    task automatic test_crc();
        build(1'b1, 8'h77);
        pulse_start();
        feed(0, NT, -1, 0);
        wait_done();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL crc_good_err: got %b required 0", err); end
        words[3] = words[3] ^ 8'h04;
        pulse_start();
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL crc_start_clear: done=%b err=%b required 0 0", done, err); end
        feed(0, NT, -1, 0);
        wait_done();
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL crc_bad_err: got %b required 1", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_ignored();
        test_reset_mid();
`ifdef LOADER_CRC_EN
        test_crc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
